// File: rtl/vme_seq_pkg.sv
// vme_seq_pkg: shared encodings, widths and FSM states for the VME command sequencer
package vme_seq_pkg;
  localparam int CMD_W  = 34;
  localparam int RD_BIT = 25;
  localparam int WR_BIT = 24;
  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WCNT, S_ISSUE, S_ACK, S_STALL, S_NEXT, S_DONE
  } state_t;
endpackage

// File: rtl/vme_seq_res_fifo.sv
// vme_seq_res_fifo: first-word-fall-through result buffer, DEPTH power of 2 (>=2)
//   clk, rst_n     clock, synchronous active-low reset
//   push, din      write strobe/data; accepted when not full or when popping the same cycle
//   pop            read strobe; ignored when empty
//   dout           head entry, valid whenever empty=0
//   empty, full    occupancy flags
module vme_seq_res_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: replays a loaded WR/RD/WAIT/END list into the VME command path
//   clk, rst_n                 clock, synchronous active-low reset
//   ld_we, ld_addr, ld_data    command RAM load {op, instr, data}; dropped while busy
//   go, abort                  start run (idle only) / stop run (wins over go)
//   vme_cmd_rd, vme_dat_wr     VME ready / completion (read data valid)
//   vme_dat_reg_out            read-back data, [15:0] used
//   start, vme_cmd_reg,
//   vme_dat_reg_in             issue strobe and the command/data presented with it
//   res_rd, res_data,
//   res_empty, res_full        FWFT read-result buffer
//   busy, done, timeout_err,
//   cmd_ptr                    run status
//   VME_SEQ_CMP_EN adds mismatch_cnt / first_fail_ptr read-data checking
module vme_cmd_sequencer
  import vme_seq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int RES_DEPTH = 16,
  parameter logic [31:0] CMD_MASK = 32'h00A80000,
  parameter int TIMEOUT = 1023,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [PTR_W-1:0]  ld_addr,
  input  logic [CMD_W-1:0]  ld_data,
  input  logic              go,
  input  logic              abort,
  input  logic              vme_cmd_rd,
  input  logic              vme_dat_wr,
  input  logic [31:0]       vme_dat_reg_out,
  output logic              start,
  output logic [31:0]       vme_cmd_reg,
  output logic [31:0]       vme_dat_reg_in,
  input  logic              res_rd,
  output logic [15:0]       res_data,
  output logic              res_empty,
  output logic              res_full,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
`ifdef VME_SEQ_CMP_EN
  output logic [15:0]       mismatch_cnt,
  output logic [PTR_W-1:0]  first_fail_ptr,
`endif
  output logic [PTR_W-1:0]  cmd_ptr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [CMD_W-1:0] ram [DEPTH];
  logic [CMD_W-1:0] cur;
  state_t state, nxt;
  logic [15:0] wcnt, hold, push_data;
  logic [TW-1:0] tcnt;
  logic [1:0] op;
  logic [15:0] instr, dat;
  logic is_rd, is_wr, tmo, can_push, push, unused_hi;
  assign op = cur[33:32];
  assign instr = cur[31:16];
  assign dat = cur[15:0];
  assign is_rd = op == OP_RD;
  assign is_wr = op == OP_WR;
  assign tmo = tcnt == TW'(TIMEOUT);
  // a pop in the same cycle frees a slot even when full
  assign can_push = !res_full || res_rd;
  assign busy = state != S_IDLE;
  assign unused_hi = ^vme_dat_reg_out[31:16];
  assign vme_cmd_reg = CMD_MASK | (start ? {16'h0, instr} | (32'(is_rd) << RD_BIT) | (32'(is_wr) << WR_BIT) : 32'h0);
  assign vme_dat_reg_in = (start && is_wr) ? {16'h0, dat} : 32'h0;
  always_ff @(posedge clk)
    if (ld_we && !busy) ram[ld_addr] <= ld_data;
  always_ff @(posedge clk)
    if (state == S_FETCH) cur <= ram[cmd_ptr];
  always_comb begin
    nxt = state;
    start = 1'b0;
    push = 1'b0;
    push_data = state == S_STALL ? hold : vme_dat_reg_out[15:0];
    case (state)
      S_IDLE:   nxt = go ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = op == OP_END ? S_DONE : op == OP_WAIT ? S_WCNT : S_ISSUE;
      S_WCNT:   nxt = wcnt == 16'h0 ? S_NEXT : S_WCNT;
      S_ISSUE: begin
        start = vme_cmd_rd;
        nxt = vme_cmd_rd ? S_ACK : tmo ? S_DONE : S_ISSUE;
      end
      S_ACK: begin
        push = vme_dat_wr && is_rd && can_push;
        nxt = !vme_dat_wr ? (tmo ? S_DONE : S_ACK) : (is_rd && !can_push) ? S_STALL : S_NEXT;
      end
      S_STALL: begin
        push = can_push;
        nxt = can_push ? S_NEXT : S_STALL;
      end
      S_NEXT:   nxt = cmd_ptr == PTR_W'(DEPTH - 1) ? S_DONE : S_FETCH;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt = S_IDLE;
      start = 1'b0;
      push = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cmd_ptr <= '0;
      wcnt <= '0;
      tcnt <= '0;
      hold <= '0;
      done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      done <= busy && nxt == S_IDLE;
      tcnt <= nxt != state ? '0 : tcnt + 1'b1;
      wcnt <= state == S_DECODE ? dat : state == S_WCNT ? wcnt - 1'b1 : wcnt;
      if (state == S_ACK) hold <= vme_dat_reg_out[15:0];
      if (state == S_IDLE && go && !abort) begin
        cmd_ptr <= '0;
        timeout_err <= 1'b0;
      end else if (state == S_NEXT && nxt == S_FETCH) begin
        cmd_ptr <= cmd_ptr + 1'b1;
      end
      // the only way out of ISSUE/ACK into DONE is an expired wait
      if ((state == S_ISSUE || state == S_ACK) && nxt == S_DONE) timeout_err <= 1'b1;
    end
  end
`ifdef VME_SEQ_CMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
      first_fail_ptr <= '0;
    end else if (state == S_IDLE && go && !abort) begin
      mismatch_cnt <= '0;
      first_fail_ptr <= '0;
    end else if (state == S_ACK && vme_dat_wr && is_rd && !abort && vme_dat_reg_out[15:0] != dat) begin
      if (mismatch_cnt == 16'h0) first_fail_ptr <= cmd_ptr;
      if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif
  vme_seq_res_fifo #(.DEPTH(RES_DEPTH), .W(16)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(push_data),
    .pop(res_rd),
    .dout(res_data),
    .empty(res_empty),
    .full(res_full)
  );
endmodule
